core_mtimer: RTL and testbench

Memory-mapped RISC-V machine timer: a free-running 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register. It produces the level-sensitive `mtimer_int` input that the core's trap handler samples for machine-timer interrupts. Software accesses both registers over a 32-bit single-cycle register bus.

---
 rtl/core_mtimer_if.sv | 39 +++
 rtl/core_mtimer.sv | 130 +++++++++++++
 tb/tb_core_mtimer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mtimer_if.sv
`default_nettype none
// ============================================================================
// Module      : core_mtimer_if
// Description : Register-bus bundle for the machine timer.
//               master : drives requests, receives responses and the
//                        interrupt level.
//               slave  : the timer side.
//               Signals:
//                 req_valid  - access request, always accepted
//                 req_write  - 1 = write, 0 = read
//                 req_addr   - byte offset (0x0/0x4 mtime, 0x8/0xC mtimecmp)
//                 req_wdata  - full-word write data
//                 rsp_valid  - response strobe, one cycle after req_valid
//                 rsp_rdata  - read data (0 for writes and faults)
//                 rsp_error  - misaligned-address fault
//                 mtimer_int - machine timer interrupt pending (level)
// Revision    : 1.0 - initial release
// ============================================================================
interface core_mtimer_if;
    logic        req_valid;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mtimer_int;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  rsp_valid, rsp_rdata, rsp_error, mtimer_int
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output rsp_valid, rsp_rdata, rsp_error, mtimer_int
    );
endinterface
`default_nettype wire

// File: rtl/core_mtimer.sv
`default_nettype none
// ============================================================================
// Module      : core_mtimer
// Description : RISC-V machine timer. Free-running 64-bit mtime advanced by a
//               TICK_DIV prescaler, 64-bit mtimecmp, and a registered
//               level interrupt mtimer_int = (mtime >= mtimecmp).
//               Ports:
//                 clk   - core clock, rising-edge
//                 rst_n - asynchronous active-low reset
//                 bus   - core_mtimer_if.slave register bus + interrupt
//               Parameters:
//                 TICK_DIV - clock cycles per mtime increment (1..65535)
// Revision    : 1.0 - initial release
// ============================================================================
module core_mtimer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    core_mtimer_if.slave      bus
);

    localparam logic [15:0] c_tick_last    = 16'(TICK_DIV - 1);
    localparam logic [1:0]  c_sel_time_lo  = 2'd0;
    localparam logic [1:0]  c_sel_time_hi  = 2'd1;
    localparam logic [1:0]  c_sel_cmp_lo   = 2'd2;
    localparam logic [1:0]  c_sel_cmp_hi   = 2'd3;

    logic [15:0] r_tick_cnt;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_int;
    logic        r_rsp_valid;
    logic        r_rsp_error;
    logic [31:0] r_rsp_rdata;

    logic        w_tick;
    logic        w_aligned;
    logic        w_wr;
    logic        w_rd;
    logic [1:0]  w_sel;
    logic        w_time_wr;
    logic [31:0] w_rdata;

    assign w_tick    = (r_tick_cnt == c_tick_last);
    assign w_aligned = (bus.req_addr[1:0] == 2'b00);
    assign w_sel     = bus.req_addr[3:2];
    // Misaligned accesses are faulted and must not touch any register.
    assign w_wr      = bus.req_valid &  bus.req_write & w_aligned;
    assign w_rd      = bus.req_valid & ~bus.req_write & w_aligned;
    assign w_time_wr = w_wr & ~w_sel[1];

    // Read mux sees pre-edge register values, so a read never observes a
    // same-cycle increment or write.
    always_comb begin
        w_rdata = 32'd0;
        case (w_sel)
            c_sel_time_lo: w_rdata = r_mtime[31:0];
            c_sel_time_hi: w_rdata = r_mtime[63:32];
            c_sel_cmp_lo:  w_rdata = r_mtimecmp[31:0];
            c_sel_cmp_hi:  w_rdata = r_mtimecmp[63:32];
            default:       w_rdata = 32'd0;
        endcase
    end

    // Prescaler is independent of mtime writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= 16'd0;
        end else if (w_tick) begin
            r_tick_cnt <= 16'd0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    // A software write to either mtime half wins over the tick that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtime <= 64'd0;
        end else if (w_time_wr) begin
            if (w_sel == c_sel_time_lo) begin
                r_mtime[31:0]  <= bus.req_wdata;
            end else begin
                r_mtime[63:32] <= bus.req_wdata;
            end
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (w_wr && (w_sel == c_sel_cmp_lo)) begin
            r_mtimecmp[31:0]  <= bus.req_wdata;
        end else if (w_wr && (w_sel == c_sel_cmp_hi)) begin
            r_mtimecmp[63:32] <= bus.req_wdata;
        end
    end

    // Compare uses the registered values, so a write lands in the interrupt
    // one edge after it updates the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int <= 1'b0;
        end else begin
            r_int <= (r_mtime >= r_mtimecmp);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_rsp_valid <= bus.req_valid;
            r_rsp_error <= bus.req_valid & ~w_aligned;
            r_rsp_rdata <= w_rd ? w_rdata : 32'd0;
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_error  = r_rsp_error;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.mtimer_int = r_int;

endmodule
`default_nettype wire

// File: tb/tb_core_mtimer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_mtimer
// Description : Self-checking bench for core_mtimer. Two instances run side
//               by side (TICK_DIV=1 and TICK_DIV=4) against a cycle-count
//               based reference model; directed scenarios are followed by
//               randomized register traffic and a mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mtimer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    core_mtimer_if bus1 ();
    core_mtimer_if bus4 ();

    core_mtimer #(.TICK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    core_mtimer #(.TICK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    // Stimulus, index 0 -> dut1, index 1 -> dut4
    logic        req_v [2];
    logic        req_w [2];
    logic [3:0]  req_a [2];
    logic [31:0] req_d [2];

    assign bus1.req_valid = req_v[0];
    assign bus1.req_write = req_w[0];
    assign bus1.req_addr  = req_a[0];
    assign bus1.req_wdata = req_d[0];
    assign bus4.req_valid = req_v[1];
    assign bus4.req_write = req_w[1];
    assign bus4.req_addr  = req_a[1];
    assign bus4.req_wdata = req_d[1];

    // Reference model: time expressed as edges since reset release
    int unsigned div   [2] = '{1, 4};
    int unsigned m_cyc [2];
    logic [63:0] m_time[2];
    logic [63:0] m_cmp [2];
    logic        m_int [2];
    logic        m_rv  [2];
    logic        m_re  [2];
    logic [31:0] m_rd  [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int k, input logic [3:0] a);
        case (a[3:2])
            2'd0:    return m_time[k][31:0];
            2'd1:    return m_time[k][63:32];
            2'd2:    return m_cmp[k][31:0];
            default: return m_cmp[k][63:32];
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cyc[k]  = 0;
            m_time[k] = 64'd0;
            m_cmp[k]  = 64'hFFFF_FFFF_FFFF_FFFF;
            m_int[k]  = 1'b0;
            m_rv[k]   = 1'b0;
            m_re[k]   = 1'b0;
            m_rd[k]   = 32'd0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic ok, tick, wr, time_wr;
            ok      = (req_a[k][1:0] == 2'b00);
            tick    = ((m_cyc[k] % div[k]) == div[k] - 1);
            wr      = req_v[k] && req_w[k] && ok;
            time_wr = wr && !req_a[k][3];
            m_rv[k] = req_v[k];
            m_re[k] = req_v[k] && !ok;
            m_rd[k] = (req_v[k] && !req_w[k] && ok) ? model_read(k, req_a[k]) : 32'd0;
            m_int[k] = (m_time[k] >= m_cmp[k]);
            m_cyc[k]++;
            if (wr) begin
                case (req_a[k][3:2])
                    2'd0:    m_time[k][31:0]  = req_d[k];
                    2'd1:    m_time[k][63:32] = req_d[k];
                    2'd2:    m_cmp[k][31:0]   = req_d[k];
                    default: m_cmp[k][63:32]  = req_d[k];
                endcase
            end
            if (tick && !time_wr) m_time[k] = m_time[k] + 64'd1;
        end
    endtask

    task automatic check_outputs();
        check_eq("d1.rsp_valid",  bus1.rsp_valid,  m_rv[0]);
        check_eq("d1.rsp_error",  bus1.rsp_error,  m_re[0]);
        check_eq("d1.rsp_rdata",  bus1.rsp_rdata,  m_rd[0]);
        check_eq("d1.mtimer_int", bus1.mtimer_int, m_int[0]);
        check_eq("d4.rsp_valid",  bus4.rsp_valid,  m_rv[1]);
        check_eq("d4.rsp_error",  bus4.rsp_error,  m_re[1]);
        check_eq("d4.rsp_rdata",  bus4.rsp_rdata,  m_rd[1]);
        check_eq("d4.mtimer_int", bus4.mtimer_int, m_int[1]);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic req(input int k, input logic w, input logic [3:0] a, input logic [31:0] d);
        req_v[k] = 1'b1;
        req_w[k] = w;
        req_a[k] = a;
        req_d[k] = d;
        step();
        req_v[k] = 1'b0;
        req_w[k] = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".d1.valid"}, bus1.rsp_valid,  0);
        check_eq({tag, ".d1.rdata"}, bus1.rsp_rdata,  0);
        check_eq({tag, ".d1.error"}, bus1.rsp_error,  0);
        check_eq({tag, ".d1.int"},   bus1.mtimer_int, 0);
        check_eq({tag, ".d4.valid"}, bus4.rsp_valid,  0);
        check_eq({tag, ".d4.int"},   bus4.mtimer_int, 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_v[k] = 1'b0; req_w[k] = 1'b0; req_a[k] = 4'h0; req_d[k] = 32'h0;
        end
        rst_n = 1'b0;
        model_reset();
        idle(2);
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle count, then read mtime lo and mtimecmp hi
        idle(9);
        req(0, 1'b0, 4'h0, 32'h0);
        req(0, 1'b0, 4'hC, 32'h0);
        check_eq("rd_cmp_hi", bus1.rsp_rdata, 32'hFFFF_FFFF);
        check_eq("idle_int",  bus1.mtimer_int, 0);

        // Interrupt rise at mtime == 20, then fall after raising cmp hi
        req(0, 1'b1, 4'h0, 32'd0);
        req(0, 1'b1, 4'h4, 32'd0);
        req(0, 1'b1, 4'h8, 32'd20);
        req(0, 1'b1, 4'hC, 32'd0);
        idle(22);
        check_eq("int_after_20", bus1.mtimer_int, 1);
        req(0, 1'b1, 4'hC, 32'd1);
        idle(2);
        check_eq("int_cleared", bus1.mtimer_int, 0);

        // 64-bit wrap with mtimecmp at max
        req(0, 1'b1, 4'h8, 32'hFFFF_FFFF);
        req(0, 1'b1, 4'hC, 32'hFFFF_FFFF);
        req(0, 1'b1, 4'h0, 32'hFFFF_FFFF);
        req(0, 1'b1, 4'h4, 32'hFFFF_FFFF);
        idle(3);
        req(0, 1'b0, 4'h4, 32'h0);
        check_eq("wrap_hi", bus1.rsp_rdata, 32'h0);

        // TICK_DIV=4: write mtime lo on a tick edge
        while ((m_cyc[1] % 4) != 3) step();
        req(1, 1'b1, 4'h0, 32'd100);
        req(1, 1'b0, 4'h0, 32'h0);
        check_eq("div4_write_wins", bus4.rsp_rdata, 32'd100);
        for (int i = 0; i < 10; i++) req(1, 1'b0, 4'h0, 32'h0);

        // Misaligned write faults, then back-to-back reads
        req(0, 1'b1, 4'h6, 32'h1234);
        check_eq("err_flag",  bus1.rsp_error, 1);
        check_eq("err_rdata", bus1.rsp_rdata, 0);
        req(0, 1'b0, 4'h8, 32'h0);
        req(0, 1'b0, 4'h0, 32'h0);
        check_eq("b2b_second_valid", bus1.rsp_valid, 1);

        // Randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    req_v[k] = 1'b1;
                    req_w[k] = 1'($urandom_range(0, 1));
                    req_a[k] = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 3) != 0) req_a[k][1:0] = 2'b00;
                    req_d[k] = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
                end else begin
                    req_v[k] = 1'b0;
                    req_w[k] = 1'b0;
                end
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            req_v[k] = 1'b0; req_w[k] = 1'b0;
        end
        step();

        // Reset mid-operation with interrupt pending and a response in flight
        req(0, 1'b1, 4'h8, 32'd0);
        req(0, 1'b1, 4'hC, 32'd0);
        idle(2);
        req_v[0] = 1'b1; req_w[0] = 1'b0; req_a[0] = 4'h0;
        step();
        check_eq("pre_rst_int",   bus1.mtimer_int, 1);
        check_eq("pre_rst_valid", bus1.rsp_valid,  1);
        req_v[0] = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("no_rsp_after_rst", bus1.rsp_valid, 0);
        idle(3);
        req(0, 1'b0, 4'h0, 32'h0);
        check_eq("restart_time", bus1.rsp_rdata, 32'd4);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
